// File: rtl/step_pkg.sv
// Shared types and defaults for the step/direction move sequencer.
package step_pkg;

    localparam int unsigned CNT_W_DEF = 10;
    localparam int unsigned PER_W_DEF = 15;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        GAP
    } state_t;

    // Move command at default widths.
    typedef struct packed {
        logic                 dir;
        logic [CNT_W_DEF-1:0] num;
        logic [PER_W_DEF-1:0] half;
    } step_cmd_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_pulse_core.sv
// Pulse generator for one move: num pulses, each low for H then high for H cycles.
module step_pulse_core #(
    parameter int unsigned CNT_W = 10,
    parameter int unsigned PER_W = 15
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic [CNT_W-1:0] num,
    input  logic [PER_W-1:0] half,
    output logic             step,
    output logic             done
);

    logic             running;
    logic [PER_W-1:0] half_cnt;
    logic [CNT_W-1:0] pulse_cnt;
    logic             last_pulse;

    // Compare against num-1 so the counter never has to reach num itself.
    assign last_pulse = (pulse_cnt == num - CNT_W'(1));

    // Half-period timing, pulse counting and the step output register.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            running   <= 1'b0;
            step      <= 1'b1;
            done      <= 1'b0;
            half_cnt  <= '0;
            pulse_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                running   <= 1'b0;
                step      <= 1'b1;
                half_cnt  <= '0;
                pulse_cnt <= '0;
            end else if (start) begin
                running   <= 1'b1;
                step      <= 1'b0;
                half_cnt  <= '0;
                pulse_cnt <= '0;
            end else if (running) begin
                if (half_cnt == half) begin
                    half_cnt <= '0;
                    if (!step) begin
                        step <= 1'b1;
                        if (last_pulse) begin
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            pulse_cnt <= pulse_cnt + CNT_W'(1);
                        end
                    end else begin
                        step <= 1'b0;
                    end
                end else begin
                    half_cnt <= half_cnt + PER_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/step_move_sequencer.sv
// Move sequencer: queues step commands and runs them with dir setup and dwell gaps.
module step_move_sequencer
    import step_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DIR_SETUP = 5,
    parameter int unsigned GAP_CYC   = 10,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned PER_W     = PER_W_DEF
) (
    input  logic                   sysclk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_dir,
    input  logic [CNT_W-1:0]       cmd_num,
    input  logic [PER_W-1:0]       cmd_half,
    input  logic                   abort,
    output logic                   step,
    output logic                   dir,
    output logic                   busy,
    output logic                   move_done,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(max_u(DIR_SETUP, GAP_CYC) + 1);

    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(DIR_SETUP - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(GAP_CYC - 1);
    localparam logic [OCC_W-1:0]  FULL_OCC   = OCC_W'(DEPTH);

    typedef struct packed {
        logic             dir;
        logic [CNT_W-1:0] num;
        logic [PER_W-1:0] half;
    } cmd_t;

    cmd_t              mem [DEPTH];
    cmd_t              head;
    cmd_t              cur;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              core_start;
    logic              core_done;
    logic              done_nxt;

    assign head       = mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_OCC);
    assign cmd_ready  = !fifo_full && !abort;
    assign push       = cmd_valid && cmd_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign dir        = cur.dir;

    // Command storage; only written on an accepted push.
    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wr_ptr] <= '{dir: cmd_dir, num: cmd_num, half: cmd_half};
        end
    end

    // FIFO pointers and occupancy; abort flushes everything.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Cycle counter shared by SETUP and GAP, cleared on every state change.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= '0;
        end else if (state == SETUP || state == GAP) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Next-state selection; abort always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (!fifo_empty && head.num != '0) state_nxt = SETUP;
                SETUP:   if (wait_cnt == SETUP_LAST) state_nxt = RUN;
                RUN:     if (core_done) state_nxt = GAP;
                GAP:     if (wait_cnt == GAP_LAST) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Per-state strobes: pop, pulse start and move completion.
    always_comb begin
        pop        = 1'b0;
        core_start = 1'b0;
        done_nxt   = 1'b0;
        if (!abort) begin
            case (state)
                IDLE: begin
                    pop      = !fifo_empty;
                    done_nxt = !fifo_empty && (head.num == '0);
                end
                SETUP:   core_start = (wait_cnt == SETUP_LAST);
                RUN:     done_nxt   = core_done;
                default: ;
            endcase
        end
    end

    // Latched command (also the dir output) and the move_done register.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            cur       <= '0;
            move_done <= 1'b0;
        end else begin
            move_done <= done_nxt;
            if (pop) cur <= head;
        end
    end

    step_pulse_core #(
        .CNT_W (CNT_W),
        .PER_W (PER_W)
    ) u_core (
        .sysclk (sysclk),
        .rst    (rst),
        .clear  (abort),
        .start  (core_start),
        .num    (cur.num),
        .half   (cur.half),
        .step   (step),
        .done   (core_done)
    );

endmodule

// File: tb/tb_step_move_sequencer.sv
// Directed bench for step_move_sequencer with a timeline model of expected outputs.
module tb_step_move_sequencer;
    import step_pkg::*;

    localparam int DEPTH = 4;
    localparam int DS    = 5;
    localparam int GAPC  = 10;
    localparam int CW    = 10;
    localparam int PW    = 15;

    logic          sysclk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [CW-1:0] cmd_num = '0;
    logic [PW-1:0] cmd_half = '0;
    logic          abort = 1'b0;
    logic          cmd_ready, step, dir, busy, move_done;
    logic [2:0]    fifo_count;

    always #5 sysclk = ~sysclk;

    step_move_sequencer #(
        .DEPTH     (DEPTH),
        .DIR_SETUP (DS),
        .GAP_CYC   (GAPC),
        .CNT_W     (CW),
        .PER_W     (PW)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_num    (cmd_num),
        .cmd_half   (cmd_half),
        .abort      (abort),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .move_done  (move_done),
        .fifo_count (fifo_count)
    );

    int vectors = 0;
    int miscompares = 0;
    int t = 0;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, t);
        end
    endtask

    // Model: queue of commands plus the timeline of the move in progress.
    step_cmd_t q[$];
    step_cmd_t c;
    int  free_at = 0, idle_at = 0, done_t = -1;
    int  mv_on = 0, mv_start = 0, mv_last = 0, mv_h = 1;
    bit  m_dir = 1'b0;
    bit  can_push;

    always @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            q.delete();
            free_at = 0; idle_at = 0; done_t = -1; mv_on = 0; m_dir = 1'b0;
        end else begin
            t++;
            if (abort) begin
                q.delete();
                mv_on = 0; done_t = -1; free_at = t + 1; idle_at = t;
            end else begin
                can_push = (q.size() < DEPTH);
                if (t >= free_at && q.size() > 0) begin
                    c = q.pop_front();
                    m_dir = c.dir;
                    if (c.num != 0) begin
                        mv_on    = 1;
                        mv_h     = int'(c.half) + 1;
                        mv_start = t + DS;
                        mv_last  = mv_start + 2 * mv_h * int'(c.num) - mv_h;
                        done_t   = mv_last + 1;
                        idle_at  = done_t + GAPC;
                        free_at  = idle_at + 1;
                    end else begin
                        mv_on = 0; done_t = t; idle_at = t; free_at = t + 1;
                    end
                end
                if (cmd_valid && can_push) q.push_back('{dir: cmd_dir, num: cmd_num, half: cmd_half});
            end
        end
    end

    // Monitors fed by the compare process.
    int falls = 0, dones = 0, dir_rise_t = -1, fall_after_rise = -1;
    bit prev_step = 1'b1, prev_dir = 1'b0;
    int exp_step;

    // Per-cycle comparison of every output against the model.
    always @(posedge sysclk) begin
        #1;
        if (rst) begin
            exp_step = (mv_on != 0 && t >= mv_start && t < mv_last) ? ((t - mv_start) / mv_h) % 2 : 1;
            chk("step", step, exp_step);
            chk("dir", dir, m_dir);
            chk("move_done", move_done, int'(t == done_t));
            chk("busy", busy, int'(q.size() != 0 || t < idle_at));
            chk("fifo_count", fifo_count, q.size());
            chk("cmd_ready", cmd_ready, int'(q.size() < DEPTH && !abort));
            if (prev_step && !step) begin
                falls++;
                if (dir_rise_t >= 0 && fall_after_rise < 0) fall_after_rise = t;
            end
            if (!prev_dir && dir) dir_rise_t = t;
            if (move_done) dones++;
        end
        prev_step = step;
        prev_dir  = dir;
    end

    int push_edge = 0;

    task automatic clr_mon();
        falls = 0; dones = 0; dir_rise_t = -1; fall_after_rise = -1;
    endtask

    task automatic push(input bit d, input int n, input int h);
        int waited;
        waited = 0;
        @(negedge sysclk);
        cmd_valid = 1'b1; cmd_dir = d; cmd_num = CW'(n); cmd_half = PW'(h);
        #1;
        while (!cmd_ready && waited < 4000) begin
            @(negedge sysclk); #1; waited++;
        end
        if (!cmd_ready) chk("push_timeout", cmd_ready, 1);
        @(posedge sysclk); #2;
        push_edge = t;
        cmd_valid = 1'b0;
    endtask

    task automatic goto_edge(input int k);
        int n;
        n = 0;
        while (t < k && n < 5000) begin
            @(posedge sysclk); #2; n++;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge sysclk);
        while (busy && w < 5000) begin
            @(negedge sysclk); w++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    int e0, e1, ae;

    initial begin
        repeat (3) @(negedge sysclk);
        rst = 1'b1;
        @(negedge sysclk); #1;
        chk("rst_step", step, 1);
        chk("rst_dir", dir, 0);
        chk("rst_move_done", move_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_cmd_ready", cmd_ready, 1);

        // Single move dir=1 num=3 H=2.
        clr_mon();
        push(1'b1, 3, 1);
        e0 = push_edge;
        goto_edge(e0 + 1);  chk("t1_dir", dir, 1);
        goto_edge(e0 + 6);  chk("t1_fall_e6", step, 0);
        goto_edge(e0 + 7);  chk("t1_low_e7", step, 0);
        goto_edge(e0 + 8);  chk("t1_rise_e8", step, 1);
        goto_edge(e0 + 16); chk("t1_done_e16", move_done, 0);
        goto_edge(e0 + 17); chk("t1_done_e17", move_done, 1);
        goto_edge(e0 + 26); chk("t1_busy_e26", busy, 1);
        goto_edge(e0 + 27); chk("t1_busy_e27", busy, 0);
        wait_idle();
        chk("t1_falls", falls, 3);
        chk("t1_dones", dones, 1);

        // Back-to-back moves, H=1 then H=4.
        clr_mon();
        push(1'b0, 2, 0);
        push(1'b1, 1, 3);
        wait_idle();
        chk("t2_dones", dones, 2);
        chk("t2_falls", falls, 3);
        chk("t2_dir_setup", fall_after_rise - dir_rise_t, DS);

        // Zero-count moves.
        clr_mon();
        push(1'b0, 0, 5);
        e0 = push_edge;
        goto_edge(e0 + 1);
        chk("t3_done_a", move_done, 1);
        chk("t3_dir_a", dir, 0);
        push(1'b1, 0, 5);
        e1 = push_edge;
        goto_edge(e1 + 1);
        chk("t3_done_b", move_done, 1);
        chk("t3_dir_b", dir, 1);
        wait_idle();
        chk("t3_falls", falls, 0);
        chk("t3_dones", dones, 2);

        // FIFO full: one running plus five pushed.
        clr_mon();
        push(1'b0, 6, 2);
        push(1'b1, 2, 1);
        push(1'b0, 3, 0);
        push(1'b1, 1, 4);
        push(1'b0, 0, 0);
        @(negedge sysclk); #1;
        chk("t4_full_count", fifo_count, 4);
        chk("t4_full_ready", cmd_ready, 0);
        push(1'b1, 2, 0);
        wait_idle();
        chk("t4_dones", dones, 6);

        // Abort in the middle of a long move with two queued.
        clr_mon();
        push(1'b1, 100, 1);
        e0 = push_edge;
        push(1'b0, 5, 0);
        push(1'b1, 5, 0);
        goto_edge(e0 + 21);
        @(negedge sysclk);
        abort = 1'b1;
        #1; chk("t5_ready_abort", cmd_ready, 0);
        @(posedge sysclk); #2;
        chk("t5_step", step, 1);
        chk("t5_fifo_count", fifo_count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_dir_hold", dir, 1);
        @(negedge sysclk);
        abort = 1'b0;
        ae = t;
        goto_edge(ae + 3);
        chk("t5_no_done", dones, 0);
        @(negedge sysclk); abort = 1'b1;
        @(negedge sysclk); abort = 1'b0;
        push(1'b0, 2, 1);
        wait_idle();
        chk("t5_after_dones", dones, 1);

        // Asynchronous reset mid-run.
        push(1'b1, 50, 2);
        e0 = push_edge;
        push(1'b0, 3, 0);
        goto_edge(e0 + 15);
        @(negedge sysclk); #3;
        rst = 1'b0;
        #1;
        chk("t6_step", step, 1);
        chk("t6_dir", dir, 0);
        chk("t6_fifo_count", fifo_count, 0);
        chk("t6_busy", busy, 0);
        repeat (2) @(negedge sysclk);
        rst = 1'b1;
        clr_mon();
        push(1'b1, 2, 0);
        wait_idle();
        chk("t6_resume_dones", dones, 1);
        chk("t6_resume_falls", falls, 2);

        repeat (3) @(negedge sysclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1);
    end

endmodule
